// File: rtl/relu_argmax.sv
// ReLU + sequential argmax readout stage: captures a vector on handshake,
// scans one element per clock and presents the winner on a valid/ready output.
module relu_argmax #(
    parameter int WIDTH = 16,
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in [0:N-1],
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [IDX_W-1:0]        max_idx,
    output logic signed [WIDTH-1:0] max_val,
    output logic                    all_zero
);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    state_t                  r_state, w_state_nxt;
    logic signed [WIDTH-1:0] w_relu [0:N-1];
    logic signed [WIDTH-1:0] r_buf  [0:N-1];
    logic signed [WIDTH-1:0] r_best_val;
    logic signed [WIDTH-1:0] w_cand;
    logic signed [WIDTH-1:0] w_best_nxt;
    logic [IDX_W-1:0]        r_best_idx;
    logic [IDX_W-1:0]        r_cnt;
    logic                    r_all_zero;
    logic                    w_accept;
    logic                    w_take;
    logic                    w_last;

    always_comb begin
        for (int i = 0; i < N; i++)
            w_relu[i] = in[i][WIDTH-1] ? '0 : in[i];
    end

    assign w_accept   = in_valid && in_ready;
    assign w_cand     = r_buf[r_cnt];
    // Strict compare keeps the lowest index on ties.
    assign w_take     = w_cand > r_best_val;
    assign w_best_nxt = w_take ? w_cand : r_best_val;
    assign w_last     = (r_cnt == IDX_W'(N - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_state_nxt = (N > 1) ? S_SCAN : S_DONE;
            S_SCAN:  if (w_last)   w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == S_IDLE) && rst_n;
        out_valid = (r_state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int i = 0; i < N; i++)
                r_buf[i] <= w_relu[i];
        end
    end

    // All ReLU'd values are >= 0 and best only grows, so a zero best at the
    // end of the scan means the whole vector was zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_best_val <= '0;
            r_best_idx <= '0;
            r_cnt      <= '0;
            r_all_zero <= 1'b0;
        end else if (w_accept) begin
            r_best_val <= w_relu[0];
            r_best_idx <= '0;
            r_cnt      <= IDX_W'(1);
            r_all_zero <= (w_relu[0] == '0);
        end else if (r_state == S_SCAN) begin
            r_best_val <= w_best_nxt;
            if (w_take) r_best_idx <= r_cnt;
            r_cnt      <= r_cnt + IDX_W'(1);
            if (w_last) r_all_zero <= (w_best_nxt == '0);
        end
    end

    assign max_idx  = r_best_idx;
    assign max_val  = r_best_val;
    assign all_zero = r_all_zero;

endmodule

// File: tb/tb_relu_argmax.sv
// Directed + randomized bench for relu_argmax (N=4, WIDTH=16) with a
// behavioural argmax reference model.
module tb_relu_argmax;

    localparam int WIDTH = 16;
    localparam int N     = 4;
    localparam int IDX_W = 2;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] in_vec [0:N-1];
    logic                    out_valid;
    logic                    out_ready;
    logic [IDX_W-1:0]        max_idx;
    logic signed [WIDTH-1:0] max_val;
    logic                    all_zero;

    int n_cmp = 0;
    int n_err = 0;

    relu_argmax #(.WIDTH(WIDTH), .N(N), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in(in_vec), .out_valid(out_valid), .out_ready(out_ready),
        .max_idx(max_idx), .max_val(max_val), .all_zero(all_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0][WIDTH-1:0] mk(input int a, input int b, input int c, input int d);
        logic [N-1:0][WIDTH-1:0] v;
        v[0] = WIDTH'(a); v[1] = WIDTH'(b); v[2] = WIDTH'(c); v[3] = WIDTH'(d);
        return v;
    endfunction

    function automatic logic [N-1:0][WIDTH-1:0] rnd_vec();
        logic [N-1:0][WIDTH-1:0] v;
        for (int i = 0; i < N; i++)
            v[i] = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom)
                                                : WIDTH'(int'($urandom_range(0, 20)) - 10);
        return v;
    endfunction

    // Reference: clamp negatives to zero, first index of the maximum wins.
    task automatic model(input logic [N-1:0][WIDTH-1:0] v, output int idx, output int val, output int az);
        int r [N];
        for (int i = 0; i < N; i++) r[i] = ($signed(v[i]) < 0) ? 0 : int'($signed(v[i]));
        idx = 0; val = r[0];
        for (int i = 1; i < N; i++)
            if (r[i] > val) begin val = r[i]; idx = i; end
        az = (val == 0) ? 1 : 0;
    endtask

    task automatic drive(input logic [N-1:0][WIDTH-1:0] v);
        for (int i = 0; i < N; i++) in_vec[i] = $signed(v[i]);
    endtask

    // Called at a negedge with the block idle; returns at a negedge, idle again.
    task automatic run_vec(input string tag, input logic [N-1:0][WIDTH-1:0] v, input int hold);
        int e_idx, e_val, e_az, lat;
        model(v, e_idx, e_val, e_az);
        chk({tag, ".in_ready_pre"}, int'(in_ready), 1);
        drive(v);
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); @(negedge clk);
            lat++;
        end
        chk({tag, ".latency"}, lat, 3);
        chk({tag, ".max_idx"}, int'(max_idx), e_idx);
        chk({tag, ".max_val"}, int'(max_val), e_val);
        chk({tag, ".all_zero"}, int'(all_zero), e_az);
        chk({tag, ".in_ready_busy"}, int'(in_ready), 0);
        for (int k = 0; k < hold; k++) begin
            drive(rnd_vec());
            in_valid = ~in_valid;
            @(posedge clk); @(negedge clk);
            chk({tag, ".hold_valid"}, int'(out_valid), 1);
            chk({tag, ".hold_idx"}, int'(max_idx), e_idx);
            chk({tag, ".hold_val"}, int'(max_val), e_val);
            chk({tag, ".hold_in_ready"}, int'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        chk({tag, ".valid_drop"}, int'(out_valid), 0);
        chk({tag, ".in_ready_post"}, int'(in_ready), 1);
        out_ready = 1'b0;
    endtask

    initial begin
        int q_idx [$], q_val [$], q_az [$];
        int e_idx, e_val, e_az, last, seen;
        logic [N-1:0][WIDTH-1:0] v;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        drive(mk(0, 0, 0, 0));
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("rst.in_ready", int'(in_ready), 0);
        chk("rst.out_valid", int'(out_valid), 0);
        chk("rst.max_idx", int'(max_idx), 0);
        chk("rst.max_val", int'(max_val), 0);
        chk("rst.all_zero", int'(all_zero), 0);
        rst_n = 1'b1;
        #1;
        chk("rst.in_ready_rel", int'(in_ready), 1);

        run_vec("basic", mk(-5, 300, 120, 299), 0);
        run_vec("tie", mk(50, 50, -1, 50), 0);
        run_vec("nonpos", mk(-1, -32768, -7, 0), 0);
        run_vec("bp", mk(7, 9, 32767, 9), 5);

        // Reset during scan must abort the vector.
        drive(mk(10, 20, 30, 40));
        in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("mrst.out_valid", int'(out_valid), 0);
        chk("mrst.in_ready", int'(in_ready), 0);
        chk("mrst.max_idx", int'(max_idx), 0);
        chk("mrst.max_val", int'(max_val), 0);
        chk("mrst.all_zero", int'(all_zero), 0);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); @(negedge clk);
            if (out_valid) seen++;
        end
        chk("mrst.no_result", seen, 0);
        run_vec("after_rst", mk(1, 2, 3, 32767), 0);

        // Streaming with both handshakes held high.
        in_valid = 1'b1; out_ready = 1'b1; last = -1;
        for (int cyc = 0; cyc < 80; cyc++) begin
            if (out_valid) begin
                if (q_idx.size() == 0) chk("stream.unexpected", 1, 0);
                else begin
                    e_idx = q_idx.pop_front(); e_val = q_val.pop_front(); e_az = q_az.pop_front();
                    chk("stream.max_idx", int'(max_idx), e_idx);
                    chk("stream.max_val", int'(max_val), e_val);
                    chk("stream.all_zero", int'(all_zero), e_az);
                end
            end
            if (in_ready) begin
                if (last >= 0) chk("stream.interval", cyc - last, 5);
                last = cyc;
                v = rnd_vec();
                drive(v);
                model(v, e_idx, e_val, e_az);
                q_idx.push_back(e_idx); q_val.push_back(e_val); q_az.push_back(e_az);
            end
            @(posedge clk); @(negedge clk);
        end
        chk("stream.accepted", (last >= 70) ? 1 : 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
